// File: rtl/debug_pkg.sv
// Shared state encodings, default command bytes and sizing helper for the UART debug unit.
// No logic; constants only.
// No flow control.
package debug_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CONT  = 3'd1;
   localparam logic [2:0] ST_STEP  = 3'd2;
   localparam logic [2:0] ST_PULSE = 3'd3;
   localparam logic [2:0] ST_SEND  = 3'd4;

   localparam logic [7:0] CMD_CONT_DEF = 8'h63;
   localparam logic [7:0] CMD_STEP_DEF = 8'h73;
   localparam logic [7:0] CMD_NEXT_DEF = 8'h6E;
   localparam logic [7:0] CMD_EXIT_DEF = 8'h65;

   function automatic int bytes_per_word(input int width);
      return (width + 7) / 8;
   endfunction

endpackage

// File: rtl/debug_word_serializer.sv
// Latches one padded word and emits it LSB byte first over the UART TX start/done handshake.
// Latency: first tx_start the cycle after load (if TX idle); wordDone one cycle after the last tx_done.
// Backpressure: tx_start only while tx_busy=0, next byte only after tx_done.
module debug_word_serializer
   import debug_pkg::*;
#(
   parameter int DATA_WIDTH = 32
)(
   input  logic                                   clock,
   input  logic                                   resetGral,
   input  logic                                   load,
   input  logic                                   oneByte,
   input  logic [bytes_per_word(DATA_WIDTH)*8-1:0] word,
   input  logic                                   tx_busy,
   input  logic                                   tx_done,
   output logic [7:0]                             tx_data,
   output logic                                   tx_start,
   output logic                                   wordDone
);

   localparam int NB = bytes_per_word(DATA_WIDTH);
   localparam int IW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [1:0] PH_IDLE  = 2'd0;
   localparam logic [1:0] PH_START = 2'd1;
   localparam logic [1:0] PH_WAIT  = 2'd2;

   logic [NB*8-1:0] shiftReg;
   logic [IW-1:0]   bytesLeft;
   logic [1:0]      phase;

   assign tx_data  = shiftReg[7:0];
   // Combinational so the strobe can never coincide with a busy transmitter.
   assign tx_start = (phase == PH_START) && !tx_busy;

   always_ff @(posedge clock or posedge resetGral) begin
      if (resetGral) begin
         shiftReg  <= '0;
         bytesLeft <= '0;
         phase     <= PH_IDLE;
         wordDone  <= 1'b0;
      end else begin
         wordDone <= 1'b0;
         case (phase)
            PH_IDLE: begin
               if (load) begin
                  shiftReg  <= word;
                  bytesLeft <= oneByte ? '0 : IW'(NB - 1);
                  phase     <= PH_START;
               end
            end
            PH_START: begin
               if (!tx_busy) phase <= PH_WAIT;
            end
            PH_WAIT: begin
               if (tx_done) begin
                  if (bytesLeft == '0) begin
                     phase    <= PH_IDLE;
                     wordDone <= 1'b1;
                  end else begin
                     bytesLeft <= bytesLeft - 1'b1;
                     shiftReg  <= shiftReg >> 8;
                     phase     <= PH_START;
                  end
               end
            end
            default: phase <= PH_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/debug_uart_unit.sv
// UART debug controller: decodes host commands, gates pipe_enable, dumps NUM_WORDS debug words.
// Latency: pipe_enable reacts to halt_i combinationally; dump starts the cycle after entering SEND.
// Backpressure: bytes paced by tx_busy/tx_done; RX bytes outside IDLE/STEP dropped. DEBUG_CHECKSUM_EN adds an XOR byte.
module debug_uart_unit
   import debug_pkg::*;
#(
   parameter int         DATA_WIDTH = 32,
   parameter int         NUM_WORDS  = 64,
   parameter int         CNT_WIDTH  = 8,
   parameter logic [7:0] CMD_CONT   = CMD_CONT_DEF,
   parameter logic [7:0] CMD_STEP   = CMD_STEP_DEF,
   parameter logic [7:0] CMD_NEXT   = CMD_NEXT_DEF,
   parameter logic [7:0] CMD_EXIT   = CMD_EXIT_DEF
)(
   input  logic                         clock,
   input  logic                         resetGral,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic [7:0]                   tx_data,
   output logic                         tx_start,
   input  logic                         tx_busy,
   input  logic                         tx_done,
   input  logic                         halt_i,
   output logic                         pipe_enable,
   output logic [$clog2(NUM_WORDS)-1:0] dbg_sel,
   input  logic [DATA_WIDTH-1:0]        dbg_data,
   output logic                         ledIdle,
   output logic                         ledStep,
   output logic                         ledSend,
   output logic                         ledCont,
   output logic [CNT_WIDTH-1:0]         sendCounter,
   output logic                         sentFlag
);

   localparam int             NB        = bytes_per_word(DATA_WIDTH);
   localparam int             SW        = $clog2(NUM_WORDS);
   localparam logic [SW-1:0]  LAST_WORD = SW'(NUM_WORDS - 1);

   logic [2:0]      state;
   logic            fromPulse;
   logic            loadPend;
   logic [SW-1:0]   wordIdx;
   logic            cmdAccept;
   logic            lastWord;
   logic            wordDone;
   logic            serLoad;
   logic            serOne;
   logic [NB*8-1:0] serWord;
   logic            dumpDone;

   assign lastWord    = (wordIdx == LAST_WORD);
   assign dbg_sel     = wordIdx;
   assign pipe_enable = ((state == ST_CONT) || (state == ST_PULSE)) && !halt_i;

   assign ledIdle = (state == ST_IDLE);
   assign ledCont = (state == ST_CONT);
   assign ledStep = (state == ST_STEP) || (state == ST_PULSE);
   assign ledSend = (state == ST_SEND);

   always_comb begin
      cmdAccept = 1'b0;
      if (rx_valid) begin
         case (state)
            ST_IDLE: cmdAccept = (rx_data == CMD_CONT) || (rx_data == CMD_STEP);
            ST_STEP: cmdAccept = (rx_data == CMD_NEXT) || (rx_data == CMD_EXIT);
            default: cmdAccept = 1'b0;
         endcase
      end
   end

`ifdef DEBUG_CHECKSUM_EN
   logic [7:0] csum;
   logic       csPhase;

   always_ff @(posedge clock or posedge resetGral) begin
      if (resetGral) begin
         csum    <= '0;
         csPhase <= 1'b0;
      end else if (state != ST_SEND) begin
         csum    <= '0;
         csPhase <= 1'b0;
      end else begin
         if (tx_start) csum <= csum ^ tx_data;
         if (wordDone && lastWord) csPhase <= 1'b1;
      end
   end

   // The checksum byte is loaded in the same cycle the last data word reports done.
   assign serLoad  = loadPend || (wordDone && lastWord && !csPhase);
   assign serOne   = !loadPend;
   assign serWord  = loadPend ? (NB*8)'(dbg_data) : (NB*8)'(csum);
   assign dumpDone = wordDone && lastWord && csPhase;
`else
   assign serLoad  = loadPend;
   assign serOne   = 1'b0;
   assign serWord  = (NB*8)'(dbg_data);
   assign dumpDone = wordDone && lastWord;
`endif

   always_ff @(posedge clock or posedge resetGral) begin
      if (resetGral) begin
         state       <= ST_IDLE;
         fromPulse   <= 1'b0;
         loadPend    <= 1'b0;
         wordIdx     <= '0;
         sendCounter <= '0;
         sentFlag    <= 1'b0;
      end else begin
         loadPend <= 1'b0;
         if (cmdAccept) begin
            sentFlag    <= 1'b0;
            sendCounter <= '0;
         end else if ((state == ST_SEND) && tx_done && (sendCounter != {CNT_WIDTH{1'b1}})) begin
            sendCounter <= sendCounter + 1'b1;
         end

         case (state)
            ST_IDLE: begin
               if (cmdAccept) state <= (rx_data == CMD_CONT) ? ST_CONT : ST_STEP;
            end
            ST_CONT: begin
               if (halt_i) begin
                  state     <= ST_SEND;
                  fromPulse <= 1'b0;
                  wordIdx   <= '0;
                  loadPend  <= 1'b1;
               end
            end
            ST_STEP: begin
               if (cmdAccept) state <= (rx_data == CMD_NEXT) ? ST_PULSE : ST_IDLE;
            end
            ST_PULSE: begin
               state     <= ST_SEND;
               fromPulse <= 1'b1;
               wordIdx   <= '0;
               loadPend  <= 1'b1;
            end
            ST_SEND: begin
               if (dumpDone) begin
                  sentFlag <= 1'b1;
                  wordIdx  <= '0;
                  state    <= fromPulse ? ST_STEP : ST_IDLE;
               end else if (wordDone && !lastWord) begin
                  wordIdx  <= wordIdx + 1'b1;
                  loadPend <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   debug_word_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .clock     (clock),
      .resetGral (resetGral),
      .load      (serLoad),
      .oneByte   (serOne),
      .word      (serWord),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done),
      .tx_data   (tx_data),
      .tx_start  (tx_start),
      .wordDone  (wordDone)
   );

endmodule

// File: tb/tb_debug_uart_unit.sv
// Scoreboarded bench: instance A (32b x 64 words) and instance B (12b x 2 words), each with a TX model.
module tb_debug_uart_unit;

   logic clock = 1'b0;
   logic resetGral = 1'b1;
   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // ---------------- instance A ----------------
   logic [7:0]  rx_dataA = 8'h00;
   logic        rx_validA = 1'b0, haltA = 1'b0;
   logic [7:0]  tx_dataA;
   logic        tx_startA, pipe_enableA;
   logic        tx_busyA = 1'b0, tx_doneA = 1'b0;
   logic [5:0]  dbg_selA;
   logic [31:0] dbg_dataA;
   logic        ledIdleA, ledStepA, ledSendA, ledContA, sentFlagA;
   logic [7:0]  sendCounterA;
   logic [7:0]  selA8;

   assign selA8     = {2'b00, dbg_selA};
   assign dbg_dataA = {selA8 ^ 8'hC3, selA8 ^ 8'h5A, selA8 + 8'h80, selA8};

   debug_uart_unit dutA (
      .clock(clock), .resetGral(resetGral), .rx_data(rx_dataA), .rx_valid(rx_validA),
      .tx_data(tx_dataA), .tx_start(tx_startA), .tx_busy(tx_busyA), .tx_done(tx_doneA),
      .halt_i(haltA), .pipe_enable(pipe_enableA), .dbg_sel(dbg_selA), .dbg_data(dbg_dataA),
      .ledIdle(ledIdleA), .ledStep(ledStepA), .ledSend(ledSendA), .ledCont(ledContA),
      .sendCounter(sendCounterA), .sentFlag(sentFlagA));

   // ---------------- instance B ----------------
   logic [7:0]  rx_dataB = 8'h00;
   logic        rx_validB = 1'b0, haltB = 1'b0;
   logic [7:0]  tx_dataB;
   logic        tx_startB, pipe_enableB;
   logic        tx_busyB = 1'b0, tx_doneB = 1'b0;
   logic [0:0]  dbg_selB;
   logic [11:0] dbg_dataB;
   logic        ledIdleB, ledStepB, ledSendB, ledContB, sentFlagB;
   logic [7:0]  sendCounterB;

   assign dbg_dataB = dbg_selB[0] ? 12'h123 : 12'hABC;

   debug_uart_unit #(.DATA_WIDTH(12), .NUM_WORDS(2), .CNT_WIDTH(8)) dutB (
      .clock(clock), .resetGral(resetGral), .rx_data(rx_dataB), .rx_valid(rx_validB),
      .tx_data(tx_dataB), .tx_start(tx_startB), .tx_busy(tx_busyB), .tx_done(tx_doneB),
      .halt_i(haltB), .pipe_enable(pipe_enableB), .dbg_sel(dbg_selB), .dbg_data(dbg_dataB),
      .ledIdle(ledIdleB), .ledStep(ledStepB), .ledSend(ledSendB), .ledCont(ledContB),
      .sendCounter(sendCounterB), .sentFlag(sentFlagB));

   // ---------------- TX models ----------------
   int busyLenA = 3;
   int cntA = 0, cntB = 0;
   logic sA, sB;

   always begin
      @(negedge clock); sA = tx_startA;
      @(posedge clock); #1;
      if (resetGral) begin
         tx_busyA = 1'b0; tx_doneA = 1'b0; cntA = 0;
      end else begin
         tx_doneA = 1'b0;
         if (sA) begin
            tx_busyA = 1'b1; cntA = busyLenA;
         end else if (tx_busyA) begin
            cntA--;
            if (cntA == 0) begin tx_busyA = 1'b0; tx_doneA = 1'b1; end
         end
      end
   end

   always begin
      @(negedge clock); sB = tx_startB;
      @(posedge clock); #1;
      if (resetGral) begin
         tx_busyB = 1'b0; tx_doneB = 1'b0; cntB = 0;
      end else begin
         tx_doneB = 1'b0;
         if (sB) begin
            tx_busyB = 1'b1; cntB = 2;
         end else if (tx_busyB) begin
            cntB--;
            if (cntB == 0) begin tx_busyB = 1'b0; tx_doneB = 1'b1; end
         end
      end
   end

   // ---------------- scoreboards / monitors ----------------
   logic [7:0] qA[$];
   logic [7:0] qB[$];
   logic       outA = 1'b0, outB = 1'b0;
   int         startsA = 0;
   int         pipeCntA = 0;

   always @(negedge clock) begin
      if (pipe_enableA) pipeCntA++;
      if (resetGral) outA = 1'b0;
      else begin
         if (tx_doneA) outA = 1'b0;
         if (tx_startA) begin
            startsA++;
            check("A_start_protocol(outstanding,busy)", {30'd0, outA, tx_busyA}, 32'd0);
            outA = 1'b1;
            if (qA.size() == 0) begin
               total++; bad++;
               $display("FAIL A_byte: unexpected byte %0h, none expected", tx_dataA);
            end else check("A_byte", tx_dataA, qA.pop_front());
         end
      end
   end

   always @(negedge clock) begin
      if (resetGral) outB = 1'b0;
      else begin
         if (tx_doneB) outB = 1'b0;
         if (tx_startB) begin
            check("B_start_protocol(outstanding,busy)", {30'd0, outB, tx_busyB}, 32'd0);
            outB = 1'b1;
            if (qB.size() == 0) begin
               total++; bad++;
               $display("FAIL B_byte: unexpected byte %0h, none expected", tx_dataB);
            end else check("B_byte", tx_dataB, qB.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic sendCmdA(input logic [7:0] b);
      @(posedge clock); #1; rx_dataA = b; rx_validA = 1'b1;
      @(posedge clock); #1; rx_validA = 1'b0;
   endtask

   task automatic sendCmdB(input logic [7:0] b);
      @(posedge clock); #1; rx_dataB = b; rx_validB = 1'b1;
      @(posedge clock); #1; rx_validB = 1'b0;
   endtask

   task automatic pushDumpA();
      for (int w = 0; w < 64; w++) begin
         logic [7:0] w8;
         w8 = 8'(w);
         qA.push_back(w8);
         qA.push_back(w8 + 8'h80);
         qA.push_back(w8 ^ 8'h5A);
         qA.push_back(w8 ^ 8'hC3);
      end
   endtask

   task automatic waitSent(input bit which, input int budget, input string nm);
      int n = 0;
      while (!(which ? sentFlagB : sentFlagA) && n < budget) begin
         @(posedge clock); #1; n++;
      end
      check(nm, {31'd0, which ? sentFlagB : sentFlagA}, 32'd1);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [7:0] bBytes[4];
      logic [7:0] cs;
      int n;

      // reset state
      repeat (3) @(posedge clock);
      #1;
      check("rst_ledIdle", {31'd0, ledIdleA}, 32'd1);
      check("rst_leds_other", {29'd0, ledStepA, ledSendA, ledContA}, 32'd0);
      check("rst_tx_start", {31'd0, tx_startA}, 32'd0);
      check("rst_pipe_enable", {31'd0, pipe_enableA}, 32'd0);
      check("rst_sendCounter", {24'd0, sendCounterA}, 32'd0);
      check("rst_sentFlag", {31'd0, sentFlagA}, 32'd0);
      check("rst_dbg_sel", {26'd0, dbg_selA}, 32'd0);
      resetGral = 1'b0;

      // 1: continuous run, halt after 10 cycles, halt wins over a simultaneous RX byte
      pushDumpA();
      pipeCntA = 0;
      sendCmdA(8'h63);
      check("cont_ledCont", {31'd0, ledContA}, 32'd1);
      repeat (10) begin @(posedge clock); #1; end
      haltA = 1'b1; rx_dataA = 8'h73; rx_validA = 1'b1;
      #1 check("halt_pipe_low_same_cycle", {31'd0, pipe_enableA}, 32'd0);
      @(posedge clock); #1; haltA = 1'b0; rx_validA = 1'b0;
      check("halt_to_send", {31'd0, ledSendA}, 32'd1);
      check("cont_pipe_cycles", pipeCntA, 32'd10);
      waitSent(1'b0, 4000, "cont_sentFlag");
      check("cont_sendCounter_sat", {24'd0, sendCounterA}, 32'd255);
      check("cont_back_idle", {31'd0, ledIdleA}, 32'd1);
      check("cont_queue_empty", qA.size(), 32'd0);

      // 6a: unknown byte in IDLE is ignored
      sendCmdA(8'h78);
      check("x_ledIdle", {31'd0, ledIdleA}, 32'd1);
      check("x_sentFlag_kept", {31'd0, sentFlagA}, 32'd1);
      check("x_counter_kept", {24'd0, sendCounterA}, 32'd255);

      // 2/3: step mode with a slow transmitter
      busyLenA = 20;
      sendCmdA(8'h73);
      check("step_ledStep", {31'd0, ledStepA}, 32'd1);
      check("step_clears_sentFlag", {31'd0, sentFlagA}, 32'd0);
      check("step_clears_counter", {24'd0, sendCounterA}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         pushDumpA();
         pipeCntA = 0;
         sendCmdA(8'h6E);
         check("pulse_ledStep", {31'd0, ledStepA}, 32'd1);
         check("pulse_pipe_high", {31'd0, pipe_enableA}, 32'd1);
         @(posedge clock); #1;
         check("pulse_to_send", {31'd0, ledSendA}, 32'd1);
         if (k == 0) begin
            repeat (100) begin @(posedge clock); #1; end
            sendCmdA(8'h63);
            check("c_in_send_ignored", {31'd0, ledSendA}, 32'd1);
            sendCmdA(8'h65);
            check("e_in_send_ignored", {31'd0, ledSendA}, 32'd1);
         end
         waitSent(1'b0, 8000, "step_sentFlag");
         check("step_pipe_one_cycle", pipeCntA, 32'd1);
         check("step_back_to_step", {31'd0, ledStepA}, 32'd1);
         check("step_sendCounter", {24'd0, sendCounterA}, 32'd255);
      end
      sendCmdA(8'h65);
      check("exit_ledIdle", {31'd0, ledIdleA}, 32'd1);

      // 4: reset in the middle of byte 37
      busyLenA = 3;
      startsA = 0;
      pushDumpA();
      sendCmdA(8'h63);
      haltA = 1'b1;
      @(posedge clock); #1; haltA = 1'b0;
      n = 0;
      do begin @(negedge clock); #1; n++; end while (startsA < 37 && n < 3000);
      check("abort_reached_byte37", startsA, 32'd37);
      check("abort_start_high_before", {31'd0, tx_startA}, 32'd1);
      resetGral = 1'b1;
      #1;
      check("abort_tx_start_async", {31'd0, tx_startA}, 32'd0);
      check("abort_sendCounter", {24'd0, sendCounterA}, 32'd0);
      check("abort_ledIdle", {31'd0, ledIdleA}, 32'd1);
      qA.delete();
      repeat (2) begin @(posedge clock); #1; end
      resetGral = 1'b0;
      pushDumpA();
      sendCmdA(8'h63);
      haltA = 1'b1;
      @(posedge clock); #1; haltA = 1'b0;
      waitSent(1'b0, 4000, "after_abort_sentFlag");
      check("after_abort_sendCounter", {24'd0, sendCounterA}, 32'd255);
      check("after_abort_queue_empty", qA.size(), 32'd0);

      // 5: 12-bit words, zero-padded top byte
      bBytes[0] = 8'hBC; bBytes[1] = 8'h0A; bBytes[2] = 8'h23; bBytes[3] = 8'h01;
      cs = 8'h00;
      for (int i = 0; i < 4; i++) begin
         qB.push_back(bBytes[i]);
         cs = cs ^ bBytes[i];
      end
`ifdef DEBUG_CHECKSUM_EN
      qB.push_back(cs);
`endif
      n = qB.size();
      sendCmdB(8'h63);
      haltB = 1'b1;
      @(posedge clock); #1; haltB = 1'b0;
      waitSent(1'b1, 500, "B_sentFlag");
      check("B_sendCounter", {24'd0, sendCounterB}, n);
      check("B_back_idle", {31'd0, ledIdleB}, 32'd1);
      check("B_queue_empty", qB.size(), 32'd0);

      repeat (5) @(posedge clock);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
